// File: rtl/smem_output_arbiter_pkg.sv
// Shared definitions for the smem output arbiter: line width, FSM states,
// trailer tag and the source index type.
package smem_pkg;

  localparam int         LINE_W      = 512;
  localparam logic [7:0] TRAILER_TAG = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    GRANT,
    TRAIL,
    DONE
  } arb_state_e;

  // Wide enough for up to 8 sources.
  typedef logic [2:0] src_idx_t;

endpackage

// File: rtl/smem_output_arbiter_if.sv
// Source-side and host-side handshake bundle of the smem output arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface smem_output_arbiter_if #(
  parameter int NUM_SRC = 4
);
  import smem_pkg::*;

  logic                      batch_start;
  logic [NUM_SRC-1:0]        src_request;
  logic [NUM_SRC-1:0]        src_permit;
  logic [NUM_SRC-1:0]        src_stall;
  logic [NUM_SRC*LINE_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_finish;
  logic [LINE_W-1:0]         host_data;
  logic                      host_valid;
  logic                      host_ready;
  logic                      all_done;
  logic [31:0]               lines_sent;
  logic                      overflow_err;

  modport master (
    output batch_start, src_request, src_data, src_valid, src_finish, host_ready,
    input  src_permit, src_stall, host_data, host_valid, all_done, lines_sent, overflow_err
  );

  modport slave (
    input  batch_start, src_request, src_data, src_valid, src_finish, host_ready,
    output src_permit, src_stall, host_data, host_valid, all_done, lines_sent, overflow_err
  );

endinterface

// File: rtl/smem_line_fifo.sv
// Synchronous line FIFO: registered count, head read straight from storage,
// simultaneous push and pop accepted even when full.
module smem_line_fifo #(
  parameter  int WIDTH = 512,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Idle head reads as zero so the output is clean without resetting storage.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define which
  // entries are live, and a resettable array would cost a reset net per bit.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/smem_output_arbiter.sv
// Round-robin output arbiter feeding a shared line FIFO to the host.
// Optional trailer lines per source are enabled by SMEM_ARB_TRAILER_EN.
module smem_output_arbiter
  import smem_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_MARGIN = 4
) (
  input logic                  clk,
  input logic                  reset_n,
  smem_output_arbiter_if.slave bus
);

  localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] STALL_LVL = CW'(FIFO_DEPTH - AFULL_MARGIN);
  localparam src_idx_t      LAST_SRC  = src_idx_t'(NUM_SRC - 1);

  arb_state_e         state;
  src_idx_t           gnt;
  src_idx_t           rr_ptr;
  src_idx_t           cand_idx;
  logic [NUM_SRC-1:0] gnt_oh;
  logic [NUM_SRC-1:0] served;
  logic [NUM_SRC-1:0] permit;
  logic [NUM_SRC-1:0] stall;
  logic [NUM_SRC-1:0] cand_vec;
  logic [NUM_SRC-1:0] hi_vec;
  logic [NUM_SRC-1:0] pick_vec;
  logic [NUM_SRC-1:0] cand_oh;
  logic               cand_found;
  logic               finish_seen;
  logic               stall_hi;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [LINE_W-1:0]  wdata;
  logic [31:0]        lines_sent;
  logic               overflow_err;
`ifdef SMEM_ARB_TRAILER_EN
  logic [31:0]        src_lines;
  logic               push_ok;
  logic [LINE_W-1:0]  trailer;
`endif

  // Candidates at or above rr_ptr win; otherwise wrap to the lowest index.
  always_comb begin
    cand_vec = bus.src_request & ~served;
    hi_vec   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hi_vec[i] = cand_vec[i] && (src_idx_t'(i) >= rr_ptr);
    end
    pick_vec = (|hi_vec) ? hi_vec : cand_vec;
    cand_oh  = pick_vec & ~(pick_vec - NUM_SRC'(1));
    cand_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pick_vec[i]) cand_idx = src_idx_t'(i);
    end
    cand_found = |cand_vec;
  end

  assign finish_seen = |(bus.src_finish & gnt_oh);
  assign stall_hi    = (fifo_count >= STALL_LVL);
  assign pop         = !fifo_empty && bus.host_ready;

`ifdef SMEM_ARB_TRAILER_EN
  assign push_ok = push && (!fifo_full || pop);

  always_comb begin
    trailer                      = '0;
    trailer[LINE_W-1 -: 8]       = TRAILER_TAG;
    trailer[7:0]                 = 8'(gnt);
    trailer[63:32]               = src_lines;
  end
`endif

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    push  = 1'b0;
    wdata = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt_oh[i]) wdata = bus.src_data[i*LINE_W +: LINE_W];
    end
    if (state == GRANT) push = |(bus.src_valid & gnt_oh);
`ifdef SMEM_ARB_TRAILER_EN
    if (state == TRAIL) begin
      push  = !fifo_full;
      wdata = trailer;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      gnt          <= '0;
      gnt_oh       <= '0;
      rr_ptr       <= '0;
      served       <= '0;
      permit       <= '0;
      stall        <= '0;
      lines_sent   <= '0;
      overflow_err <= 1'b0;
`ifdef SMEM_ARB_TRAILER_EN
      src_lines    <= '0;
`endif
    end else begin
      if (pop) lines_sent <= lines_sent + 32'd1;
      if (push && fifo_full && !pop) overflow_err <= 1'b1;
`ifdef SMEM_ARB_TRAILER_EN
      if (state == GRANT && push_ok) src_lines <= src_lines + 32'd1;
`endif
      case (state)
        IDLE, DONE: begin
          if (bus.batch_start) begin
            served     <= '0;
            lines_sent <= '0;
            state      <= ARB;
          end
        end
        ARB: begin
          if (&served) begin
            state <= DONE;
          end else if (cand_found) begin
            gnt    <= cand_idx;
            gnt_oh <= cand_oh;
            permit <= cand_oh;
            stall  <= stall_hi ? cand_oh : '0;
            state  <= GRANT;
`ifdef SMEM_ARB_TRAILER_EN
            src_lines <= '0;
`endif
          end
        end
        GRANT: begin
          if (finish_seen) begin
            served <= served | gnt_oh;
            rr_ptr <= (gnt == LAST_SRC) ? '0 : gnt + 1'b1;
            permit <= '0;
            stall  <= '0;
`ifdef SMEM_ARB_TRAILER_EN
            state  <= TRAIL;
`else
            state  <= ARB;
`endif
          end else begin
            stall <= stall_hi ? gnt_oh : '0;
          end
        end
`ifdef SMEM_ARB_TRAILER_EN
        TRAIL: begin
          if (!fifo_full) state <= ARB;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  smem_line_fifo #(
    .WIDTH (LINE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (bus.host_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.src_permit   = permit;
  assign bus.src_stall    = stall;
  assign bus.host_valid   = !fifo_empty;
  assign bus.all_done     = (state == DONE) && fifo_empty;
  assign bus.lines_sent   = lines_sent;
  assign bus.overflow_err = overflow_err;

endmodule

// File: tb/tb_smem_output_arbiter.sv
// Directed bench for smem_output_arbiter: grant order, round robin, stall,
// overflow, optional trailers and asynchronous reset, with a line scoreboard.
module tb_smem_output_arbiter;
  import smem_pkg::*;

  localparam int NUM_SRC = 4;
  localparam int DEPTH   = 16;
  localparam int MARGIN  = 4;
`ifdef SMEM_ARB_TRAILER_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  smem_output_arbiter_if #(.NUM_SRC(NUM_SRC)) bus ();

  smem_output_arbiter #(
    .NUM_SRC      (NUM_SRC),
    .FIFO_DEPTH   (DEPTH),
    .AFULL_MARGIN (MARGIN)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int                n_checks = 0;
  int                n_pass   = 0;
  int                stall_at = -1;
  logic [LINE_W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [LINE_W-1:0] mk_line(input int src, input int idx);
    logic [LINE_W-1:0] l;
    l              = {16{32'h5EED0000 ^ 32'(idx * 7 + src * 131)}};
    l[511:504]     = 8'h3C;
    l[7:0]         = 8'(src);
    l[63:32]       = 32'(idx);
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] mk_trailer(input int src, input int n);
    logic [LINE_W-1:0] l;
    l          = '0;
    l[511:504] = 8'hA5;
    l[7:0]     = 8'(src);
    l[63:32]   = 32'(n);
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Host-side scoreboard: inputs are stable at the falling edge, so a line
  // seen valid and ready here is popped on the next rising edge.
  always @(negedge clk) begin
    if (reset_n && bus.host_valid && bus.host_ready) begin
      check("host_line_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        check("host_data", bus.host_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  // Act as whichever source is granted next: send n_lines, keep the first
  // n_keep in the scoreboard, then finish and wait for the permit to drop.
  task automatic serve(input int n_lines, input bit obey, input int n_keep, output int who);
    int guard;
    int sent;
    who   = -1;
    guard = 0;
    while (bus.src_permit == '0 && guard < 200) begin
      step();
      guard++;
    end
    check("grant_seen", (bus.src_permit != '0), 1);
    if (bus.src_permit == '0) return;
    check("permit_onehot", $onehot(bus.src_permit), 1);
    for (int i = 0; i < NUM_SRC; i++) if (bus.src_permit[i]) who = i;

    sent  = 0;
    guard = 0;
    while (sent < n_lines && guard < 2000) begin
      if (bus.src_stall[who] && stall_at < 0) stall_at = sent;
      if (obey && bus.src_stall[who]) begin
        bus.src_valid = '0;
      end else begin
        bus.src_data[who*LINE_W +: LINE_W] = mk_line(who, sent);
        bus.src_valid                      = '0;
        bus.src_valid[who]                 = 1'b1;
        if (sent < n_keep) exp_q.push_back(mk_line(who, sent));
        sent++;
      end
      step();
      guard++;
    end
    check("lines_driven", sent, n_lines);

    bus.src_valid       = '0;
    bus.src_finish[who] = 1'b1;
    step();
    guard = 0;
    while (bus.src_permit[who] && guard < 10) begin
      step();
      guard++;
    end
    check("permit_drop", bus.src_permit[who], 0);
    bus.src_finish[who]  = 1'b0;
    bus.src_request[who] = 1'b0;
`ifdef SMEM_ARB_TRAILER_EN
    exp_q.push_back(mk_trailer(who, (n_keep < sent) ? n_keep : sent));
`endif
  endtask

  task automatic start_batch();
    bus.batch_start = 1'b1;
    step();
    bus.batch_start = 1'b0;
  endtask

  task automatic end_batch(input string tag, input int exp_lines);
    int guard;
    guard = 0;
    while (!bus.all_done && guard < 500) begin
      step();
      guard++;
    end
    check({tag, "_all_done"}, bus.all_done, 1);
    check({tag, "_lines_sent"}, bus.lines_sent, exp_lines);
    check({tag, "_scoreboard_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int who;
    int order [NUM_SRC];
    int guard;

    bus.batch_start = 1'b0;
    bus.src_request = '0;
    bus.src_data    = '0;
    bus.src_valid   = '0;
    bus.src_finish  = '0;
    bus.host_ready  = 1'b0;

    // Reset values.
    #1;
    check("rst_permit", bus.src_permit, 0);
    check("rst_stall", bus.src_stall, 0);
    check("rst_host_valid", bus.host_valid, 0);
    check("rst_host_data", bus.host_data, 0);
    check("rst_all_done", bus.all_done, 0);
    check("rst_lines_sent", bus.lines_sent, 0);
    check("rst_overflow", bus.overflow_err, 0);
    #20;
    reset_n = 1'b1;
    step();

    // Batch 1: all sources, 3 lines each; a stray batch_start mid-batch is ignored.
    bus.host_ready = 1'b1;
    start_batch();
    bus.src_request = '1;
    for (int k = 0; k < NUM_SRC; k++) begin
      serve(3, 1'b1, 3, who);
      order[k] = who;
      if (k == 0) start_batch();
    end
    for (int k = 0; k < NUM_SRC; k++) check($sformatf("b1_grant_%0d", k), order[k], k);
    end_batch("b1", 12 + 4 * TRL);

    // Batch 2: rr_ptr left at 2 by source 1, then sources 0 and 3 contend.
    start_batch();
    bus.src_request[1] = 1'b1;
    serve(1, 1'b1, 1, who);
    check("b2_first_grant", who, 1);
    bus.src_request[0] = 1'b1;
    bus.src_request[3] = 1'b1;
    serve(1, 1'b1, 1, who);
    check("b2_rr_grant_a", who, 3);
    serve(1, 1'b1, 1, who);
    check("b2_rr_grant_b", who, 0);
    bus.src_request[2] = 1'b1;
    serve(5, 1'b1, 5, who);
    check("b2_last_grant", who, 2);
    end_batch("b2", 8 + 4 * TRL);

    // Batch 3: 20 lines into a 16-deep FIFO with the host stalled.
    start_batch();
    bus.host_ready     = 1'b0;
    bus.src_request[1] = 1'b1;
    stall_at           = -1;
    fork
      serve(20, 1'b1, 20, who);
      begin
        repeat (60) step();
        check("b3_overflow_clear", bus.overflow_err, 0);
        check("b3_stall_held", bus.src_stall, 4'b0010);
        bus.host_ready = 1'b1;
      end
    join
    check("b3_grant", who, 1);
    check("b3_stall_after_lines", stall_at, 13);
    bus.src_request = 4'b1101;
    for (int k = 0; k < 3; k++) serve(0, 1'b1, 0, who);
    check("b3_overflow_still_clear", bus.overflow_err, 0);
    end_batch("b3", 20 + 4 * TRL);

    // Batch 4: a source ignoring stall pushes 17 lines; the 17th is dropped.
    start_batch();
    bus.host_ready     = 1'b0;
    bus.src_request[0] = 1'b1;
    serve(17, 1'b0, 16, who);
    check("b4_overflow_set", bus.overflow_err, 1);
    check("b4_host_valid", bus.host_valid, 1);
    bus.host_ready  = 1'b1;
    bus.src_request = 4'b1110;
    for (int k = 0; k < 3; k++) serve(0, 1'b1, 0, who);
    end_batch("b4", 16 + 4 * TRL);
    check("b4_overflow_sticky", bus.overflow_err, 1);

    // Batch 5: asynchronous reset in the middle of a grant with 7 lines buffered.
    start_batch();
    bus.host_ready     = 1'b0;
    bus.src_request[0] = 1'b1;
    guard = 0;
    while (bus.src_permit == '0 && guard < 200) begin
      step();
      guard++;
    end
    check("b5_grant", bus.src_permit, 4'b0001);
    for (int i = 0; i < 7; i++) begin
      bus.src_data[LINE_W-1:0] = mk_line(0, i);
      bus.src_valid            = 4'b0001;
      step();
    end
    bus.src_valid = '0;
    step();
    check("b5_pre_host_valid", bus.host_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("b5_rst_host_valid", bus.host_valid, 0);
    check("b5_rst_permit", bus.src_permit, 0);
    check("b5_rst_lines_sent", bus.lines_sent, 0);
    check("b5_rst_overflow", bus.overflow_err, 0);
    exp_q.delete();
    #2;
    reset_n         = 1'b1;
    bus.src_request = '1;
    repeat (4) step();
    check("b5_idle_no_permit", bus.src_permit, 0);
    check("b5_idle_lines_sent", bus.lines_sent, 0);
    start_batch();
    guard = 0;
    while (bus.src_permit == '0 && guard < 20) begin
      step();
      guard++;
    end
    check("b5_rr_reset_grant", bus.src_permit, 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
